// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcode and func3 constants, default width,
// and the ID/EX control bundle.
package rv32i_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Major opcodes, inst[6:2] (inst[1:0] must be 2'b11)
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  // ALU func3 encodings
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Control bits that travel with an instruction and are cleared by bubbles
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic illegal;
  } ctrl_t;

  // True for the opcodes that carry a shift amount in the immediate field
  function automatic logic is_shift_imm(input logic [4:0] opcode, input logic [2:0] func3);
    return (opcode == OP_IMM) && ((func3 == F3_SLL) || (func3 == F3_SR));
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts every RV32I immediate format from the
// instruction word, sign-extended to XLEN.
module imm_gen
  import rv32i_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] imm_s,
  output logic [XLEN-1:0] imm_b,
  output logic [XLEN-1:0] imm_u,
  output logic [XLEN-1:0] imm_j
);

  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

endmodule

// File: rtl/id_ex_stage.sv
// Instruction decode, load-use hazard detection and the ID/EX pipeline
// register for the 5-stage RV32I core.
module id_ex_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [4:0]      ex_opcode,
  output logic [2:0]      ex_func3,
  output logic            ex_func7,
  output logic [XLEN-1:0] ex_operand1,
  output logic [XLEN-1:0] ex_operand2,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_illegal
);

  logic [4:0]      opcode;
  logic [2:0]      func3;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic            use_rs1, use_rs2;
  logic            d_func7;
  logic [XLEN-1:0] d_operand1, d_operand2, d_imm;
  ctrl_t           d_ctrl;
  logic            hazard;
  logic            load_en;

  assign opcode   = if_inst[6:2];
  assign func3    = if_inst[14:12];
  assign rd       = if_inst[11:7];
  assign rs1_addr = if_inst[19:15];
  assign rs2_addr = if_inst[24:20];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst  (if_inst),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  // Decode: operand selection, immediate, func7 qualifier, source usage and control
  always_comb begin
    use_rs1          = 1'b0;
    use_rs2          = 1'b0;
    d_func7          = 1'b0;
    d_operand1       = rs1_data;
    d_operand2       = rs2_data;
    d_imm            = '0;
    d_ctrl           = '0;
    d_ctrl.illegal   = 1'b1;
    if (if_inst[1:0] == 2'b11) begin
      d_ctrl.illegal = 1'b0;
      case (opcode)
        OP_REG: begin
          use_rs1          = 1'b1;
          use_rs2          = 1'b1;
          d_func7          = if_inst[30];
          d_ctrl.reg_write = 1'b1;
        end
        OP_IMM: begin
          use_rs1          = 1'b1;
          d_imm            = imm_i;
          d_ctrl.reg_write = 1'b1;
          d_func7          = (func3 == F3_SR) ? if_inst[30] : 1'b0;
          // Shift immediates hand the ALU a clean shamt; the
          // arithmetic/logical selector already rides on func7.
          d_operand2       = is_shift_imm(opcode, func3) ? XLEN'(if_inst[24:20]) : imm_i;
        end
        OP_LOAD: begin
          use_rs1          = 1'b1;
          d_operand2       = imm_i;
          d_imm            = imm_i;
          d_ctrl.reg_write = 1'b1;
          d_ctrl.mem_read  = 1'b1;
        end
        OP_JALR: begin
          use_rs1          = 1'b1;
          d_operand1       = if_pc;
          d_operand2       = imm_i;
          d_imm            = imm_i;
          d_ctrl.reg_write = 1'b1;
        end
        OP_STORE: begin
          use_rs1          = 1'b1;
          use_rs2          = 1'b1;
          d_operand2       = imm_s;
          d_imm            = imm_s;
          d_ctrl.mem_write = 1'b1;
        end
        OP_BRANCH: begin
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          d_imm   = imm_b;
        end
        OP_LUI: begin
          d_operand1       = '0;
          d_operand2       = imm_u;
          d_imm            = imm_u;
          d_ctrl.reg_write = 1'b1;
        end
        OP_AUIPC: begin
          d_operand1       = if_pc;
          d_operand2       = imm_u;
          d_imm            = imm_u;
          d_ctrl.reg_write = 1'b1;
        end
        OP_JAL: begin
          d_operand1       = if_pc;
          d_operand2       = imm_j;
          d_imm            = imm_j;
          d_ctrl.reg_write = 1'b1;
        end
        default: d_ctrl.illegal = 1'b1;
      endcase
    end
    // Writes to x0 are architecturally discarded
    if (rd == 5'd0) d_ctrl.reg_write = 1'b0;
  end

  // Load-use hazard: the load in EX writes a register this instruction reads
  always_comb begin
    hazard = if_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
             ((use_rs1 & (rs1_addr == ex_rd)) | (use_rs2 & (rs2_addr == ex_rd)));
    id_stall = ~flush & (ex_stall | hazard);
    load_en  = ~flush & ~ex_stall & ~hazard & if_valid;
  end

  // Valid and control bits: flush beats stall, stall holds, otherwise bubble or load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid     <= load_en;
      ex_reg_write <= load_en & d_ctrl.reg_write;
      ex_mem_read  <= load_en & d_ctrl.mem_read;
      ex_mem_write <= load_en & d_ctrl.mem_write;
      ex_illegal   <= load_en & d_ctrl.illegal;
    end
  end

  // Datapath fields only move when a real instruction is loaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_opcode   <= '0;
      ex_func3    <= '0;
      ex_func7    <= 1'b0;
      ex_operand1 <= '0;
      ex_operand2 <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
      ex_rd       <= '0;
    end else if (load_en) begin
      ex_opcode   <= opcode;
      ex_func3    <= func3;
      ex_func7    <= d_func7;
      ex_operand1 <= d_operand1;
      ex_operand2 <= d_operand2;
      ex_rs1_data <= rs1_data;
      ex_rs2_data <= rs2_data;
      ex_imm      <= d_imm;
      ex_pc       <= if_pc;
      ex_rd       <= rd;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage with a fixed-content register file model.
module tb_id_ex_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_inst;
  logic [4:0]      rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            ex_stall, flush, id_stall;
  logic            ex_valid;
  logic [4:0]      ex_opcode;
  logic [2:0]      ex_func3;
  logic            ex_func7;
  logic [XLEN-1:0] ex_operand1, ex_operand2, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic [4:0]      ex_rd;
  logic            ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Register file: x0 = 0, xN = 0x1000 + N
  function automatic logic [XLEN-1:0] rf(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : (32'h1000 + {27'd0, a});
  endfunction

  assign rs1_data = rf(rs1_addr);
  assign rs2_data = rf(rs2_addr);

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .ex_stall     (ex_stall),
    .flush        (flush),
    .id_stall     (id_stall),
    .ex_valid     (ex_valid),
    .ex_opcode    (ex_opcode),
    .ex_func3     (ex_func3),
    .ex_func7     (ex_func7),
    .ex_operand1  (ex_operand1),
    .ex_operand2  (ex_operand2),
    .ex_rs1_data  (ex_rs1_data),
    .ex_rs2_data  (ex_rs2_data),
    .ex_imm       (ex_imm),
    .ex_pc        (ex_pc),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_illegal   (ex_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
  endtask

  initial begin
    rst = 1'b1; ex_stall = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #2;
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_regwr", {31'd0, ex_reg_write}, 32'd0);
    check("rst_op2", ex_operand2, 32'd0);
    tick();
    rst = 1'b0;

    // addi x1,x0,5
    drive(1'b1, 32'h0, 32'h00500093);
    #1 check("addi_stall", {31'd0, id_stall}, 32'd0);
    tick();
    check("addi_opcode", {27'd0, ex_opcode}, 32'h04);
    check("addi_op1", ex_operand1, 32'd0);
    check("addi_op2", ex_operand2, 32'd5);
    check("addi_rd", {27'd0, ex_rd}, 32'd1);
    check("addi_regwr", {31'd0, ex_reg_write}, 32'd1);
    check("addi_valid", {31'd0, ex_valid}, 32'd1);

    // lw x2,4(x1)
    drive(1'b1, 32'h4, 32'h0040A103);
    tick();
    check("lw_memrd", {31'd0, ex_mem_read}, 32'd1);
    check("lw_op1", ex_operand1, 32'h1001);
    check("lw_op2", ex_operand2, 32'd4);
    check("lw_rd", {27'd0, ex_rd}, 32'd2);

    // add x3,x2,x1 -> load-use hazard on x2
    drive(1'b1, 32'h8, 32'h001101B3);
    #1 check("hz_stall", {31'd0, id_stall}, 32'd1);
    tick();
    check("hz_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("hz_bubble_memrd", {31'd0, ex_mem_read}, 32'd0);
    check("hz_bubble_regwr", {31'd0, ex_reg_write}, 32'd0);
    check("hz_stall_clear", {31'd0, id_stall}, 32'd0);
    tick();
    check("add_valid", {31'd0, ex_valid}, 32'd1);
    check("add_op1", ex_operand1, 32'h1002);
    check("add_op2", ex_operand2, 32'h1001);
    check("add_rd", {27'd0, ex_rd}, 32'd3);
    check("add_func7", {31'd0, ex_func7}, 32'd0);

    // sub x4,x1,x2
    drive(1'b1, 32'hC, 32'h40208233);
    tick();
    check("sub_func7", {31'd0, ex_func7}, 32'd1);
    check("sub_op2", ex_operand2, 32'h1002);

    // srai x6,x1,3
    drive(1'b1, 32'h10, 32'h4030D313);
    tick();
    check("srai_func7", {31'd0, ex_func7}, 32'd1);
    check("srai_func3", {29'd0, ex_func3}, 32'd5);
    check("srai_op2", ex_operand2, 32'd3);
    check("srai_op1", ex_operand1, 32'h1001);

    // beq x1,x2,-8 at 0x100
    drive(1'b1, 32'h100, 32'hFE208CE3);
    tick();
    check("beq_imm", ex_imm, 32'hFFFFFFF8);
    check("beq_regwr", {31'd0, ex_reg_write}, 32'd0);
    check("beq_op2", ex_operand2, 32'h1002);
    check("beq_pc", ex_pc, 32'h100);

    // lui x5,0x12345 under flush, then again without
    drive(1'b1, 32'h104, 32'h123452B7);
    flush = 1'b1;
    #1 check("flush_stall", {31'd0, id_stall}, 32'd0);
    tick();
    check("flush_valid", {31'd0, ex_valid}, 32'd0);
    flush = 1'b0;
    tick();
    check("lui_op2", ex_operand2, 32'h12345000);
    check("lui_op1", ex_operand1, 32'd0);
    check("lui_rd", {27'd0, ex_rd}, 32'd5);

    // Hold for 3 cycles with a new instruction presented
    ex_stall = 1'b1;
    drive(1'b1, 32'h108, 32'h00900393);
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_id_stall", {31'd0, id_stall}, 32'd1);
      tick();
      check("stall_hold_op2", ex_operand2, 32'h12345000);
      check("stall_hold_rd", {27'd0, ex_rd}, 32'd5);
      check("stall_hold_valid", {31'd0, ex_valid}, 32'd1);
    end
    rst = 1'b1;
    #1;
    check("rststall_valid", {31'd0, ex_valid}, 32'd0);
    check("rststall_op2", ex_operand2, 32'd0);
    check("rststall_rd", {27'd0, ex_rd}, 32'd0);
    check("rststall_regwr", {31'd0, ex_reg_write}, 32'd0);
    tick();
    rst = 1'b0;
    ex_stall = 1'b0;

    // addi x7,x0,9, then stall+flush together: flush wins
    tick();
    check("addi9_op2", ex_operand2, 32'd9);
    check("addi9_valid", {31'd0, ex_valid}, 32'd1);
    ex_stall = 1'b1; flush = 1'b1;
    #1 check("sf_id_stall", {31'd0, id_stall}, 32'd0);
    tick();
    check("sf_valid", {31'd0, ex_valid}, 32'd0);
    ex_stall = 1'b0; flush = 1'b0;

    // sw x2,8(x1), then an empty slot
    drive(1'b1, 32'h200, 32'h0020A423);
    tick();
    check("sw_memwr", {31'd0, ex_mem_write}, 32'd1);
    check("sw_op2", ex_operand2, 32'd8);
    check("sw_rs2", ex_rs2_data, 32'h1002);
    check("sw_regwr", {31'd0, ex_reg_write}, 32'd0);
    if_valid = 1'b0;
    tick();
    check("idle_valid", {31'd0, ex_valid}, 32'd0);
    check("idle_memwr", {31'd0, ex_mem_write}, 32'd0);

    // Illegal all-zero word
    drive(1'b1, 32'h204, 32'h00000000);
    tick();
    check("ill_illegal", {31'd0, ex_illegal}, 32'd1);
    check("ill_valid", {31'd0, ex_valid}, 32'd1);
    check("ill_ctrl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
